qq_arbiter: RTL and testbench
=============================

QQ_ARBITER -- requirements
Module: qq_arbiter

Interface
REQ-001 Parameter W, default 32: key width, equal to the QuickQ W.
REQ-002 Parameter N, default 4: number of requesters, N>=2; localparam NW=$clog2(N).
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_enq  input  N  per-requester enqueue request, held until ack.
REQ-006 req_deq  input  N  per-requester dequeue request, held until ack.
REQ-007 req_key  input  N*W  enqueue keys; requester i occupies bits [i*W +: W].
REQ-008 ack  output  N  one-cycle completion pulse to the served requester.
REQ-009 err  output  N  qualifies ack: request rejected (full/empty); only exists functionally under QQ_ARB_ERR_EN.
REQ-010 rsp_key  output  W  dequeued key, valid while ack is high for a dequeue.
REQ-011 q_rdy, q_full, q_empty  input  1 each  QuickQ ready and full/empty status.
REQ-012 q_dout  input  W  QuickQ head (minimum) key.
REQ-013 q_enq, q_deq  output  1 each  one-cycle command pulses to QuickQ.
REQ-014 q_din  output  W  key presented to QuickQ, valid with q_enq.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 gnt_id  output  NW  index of the requester being served; 0 in IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if q_rdy=1 and any eligible request exists, latch winner id, op and key, then go to ISSUE; otherwise stay in IDLE.
REQ-019 Eligibility: requester i is eligible if req_enq[i] or req_deq[i] is high; if both are high, the enqueue is served first and the dequeue stays pending.
REQ-020 Round-robin: the search starts at ptr and proceeds ptr+1 ... N-1, 0, ... with modulo-N wrap; ptr becomes winner+1 (mod N) in RESP.
REQ-021 ISSUE: pulse q_enq (q_din = latched key) or q_deq for exactly one cycle; for a dequeue, capture q_dout into rsp_key in the same cycle; then go to WAIT.
REQ-022 WAIT: stay in WAIT while q_rdy=0; go to RESP on the first cycle q_rdy=1.
REQ-023 RESP: ack[gnt_id]=1 for one cycle, all other ack bits 0; then go to IDLE.
REQ-024 A new grant is possible no earlier than the cycle after RESP, so there are never back-to-back acks.
REQ-025 Latency from accept (IDLE) to ack is 3 cycles plus the number of QuickQ busy cycles.
REQ-026 Requests that change in ISSUE, WAIT or RESP do not alter the in-flight transaction; the latched values are used.
REQ-027 At most one of q_enq and q_deq is high in any cycle; both are 0 outside ISSUE.
REQ-028 rsp_key holds its last value between dequeues.

Reset
REQ-029 When rst=1: state=IDLE, ptr=0, and ack, err, q_enq, q_deq, busy and gnt_id are 0.
REQ-030 rsp_key and q_din are 0 during reset.
REQ-031 Reset mid-transaction abandons the transaction: no ack is issued, and the requester must re-present its request.

Configuration
REQ-032 Macro QQ_ARB_ERR_EN.
REQ-033 With QQ_ARB_ERR_EN defined:
- An enqueue with q_full=1 or a dequeue with q_empty=1 is still granted.
- The FSM goes IDLE->RESP directly; no q_enq or q_deq is issued.
- ack and err are both pulsed together.
REQ-034 Without QQ_ARB_ERR_EN:
- Enqueues are eligible only while q_full=0, and dequeues only while q_empty=0.
- Ineligible requests wait without being acked.
- err is tied to 0.

Structure
REQ-035 qq_pkg holds the FSM state typedef (arb_state_t) and the op typedef (OP_ENQ, OP_DEQ).
REQ-036 The round-robin picker is a separate combinational sub-module, qq_rr_pick:
- Inputs: request vector and ptr.
- Outputs: valid and winner index.

Verification
REQ-037 Single enqueue: req_enq[2]=1 with key 0x15 on an idle, empty queue -> q_enq pulse with q_din=0x15, then ack[2] after q_rdy returns, err=0.
REQ-038 Fairness: all four requesters enqueue continuously from ptr=0 -> grant order 0,1,2,3,0; no requester is served twice before the others.
REQ-039 Dequeue: queue holds {0x03,0x09}; req_deq[1] -> rsp_key=0x03 with ack[1], and the next dequeue returns 0x09.
REQ-040 Reject path:
- With QQ_ARB_ERR_EN, a dequeue on an empty queue -> ack[0] and err[0] in the cycle after grant, with no q_deq.
- Without the macro -> no ack until an enqueue makes the queue non-empty.
REQ-041 Simultaneous requests: req_enq[3]=req_deq[3]=1 -> the enqueue is served first, then the dequeue on a later grant.
REQ-042 Reset mid-operation: rst asserted in WAIT -> all outputs 0 immediately, no ack, and ptr=0 after release.

Source files
------------

// File: rtl/qq_pkg.sv
// Shared types for the QuickQ front-end arbiter: FSM state and operation kind.
package qq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_t;

endpackage

// File: rtl/qq_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo N.
module qq_rr_pick #(
    parameter int N  = 4,
    parameter int NW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic          valid,
    output logic [NW-1:0] idx
);

    // Scan from the farthest offset down so the closest candidate to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = NW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/qq_arbiter.sv
// N-way round-robin arbiter in front of a single QuickQ priority queue.
// Optional QQ_ARB_ERR_EN: grant full/empty-rejected requests and answer them with ack+err.
module qq_arbiter
    import qq_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_enq,
    input  logic [N-1:0]          req_deq,
    input  logic [N*W-1:0]        req_key,
    output logic [N-1:0]          ack,
    output logic [N-1:0]          err,
    output logic [W-1:0]          rsp_key,
    input  logic                  q_rdy,
    input  logic                  q_full,
    input  logic                  q_empty,
    input  logic [W-1:0]          q_dout,
    output logic                  q_enq,
    output logic                  q_deq,
    output logic [W-1:0]          q_din,
    output logic                  busy,
    output logic [$clog2(N)-1:0]  gnt_id
);

    localparam int NW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    arb_state_t     state;
    op_t            cur_op;
    logic [NW-1:0]  ptr;

    logic [N-1:0]   enq_ok;
    logic [N-1:0]   deq_ok;
    logic [N-1:0]   elig;
    logic           pick_valid;
    logic [NW-1:0]  pick_idx;
    op_t            pick_op;
    logic [W-1:0]   pick_key;

`ifdef QQ_ARB_ERR_EN
    logic [N-1:0]   err_r;
    logic           pick_rej;

    assign enq_ok   = req_enq;
    assign deq_ok   = req_deq;
    assign pick_rej = (pick_op == OP_ENQ) ? q_full : q_empty;
    assign err      = err_r;
`else
    // A request whose queue condition blocks it simply stays pending.
    assign enq_ok = req_enq & {N{~q_full}};
    assign deq_ok = req_deq & {N{~q_empty}};
    assign err    = '0;
`endif

    assign elig     = enq_ok | deq_ok;
    assign pick_op  = enq_ok[pick_idx] ? OP_ENQ : OP_DEQ;
    assign pick_key = req_key[int'(pick_idx)*W +: W];

    qq_rr_pick #(
        .N  (N),
        .NW (NW)
    ) u_pick (
        .req   (elig),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_op  <= OP_ENQ;
            ptr     <= '0;
            ack     <= '0;
            q_enq   <= 1'b0;
            q_deq   <= 1'b0;
            q_din   <= '0;
            rsp_key <= '0;
            busy    <= 1'b0;
            gnt_id  <= '0;
`ifdef QQ_ARB_ERR_EN
            err_r   <= '0;
`endif
        end else begin
            ack   <= '0;
            q_enq <= 1'b0;
            q_deq <= 1'b0;
`ifdef QQ_ARB_ERR_EN
            err_r <= '0;
`endif
            case (state)
                IDLE: begin
                    if (q_rdy && pick_valid) begin
                        gnt_id <= pick_idx;
                        cur_op <= pick_op;
                        q_din  <= pick_key;
                        busy   <= 1'b1;
`ifdef QQ_ARB_ERR_EN
                        if (pick_rej) begin
                            state <= RESP;
                            ack   <= ONE << pick_idx;
                            err_r <= ONE << pick_idx;
                        end else begin
                            state <= ISSUE;
                            q_enq <= (pick_op == OP_ENQ);
                            q_deq <= (pick_op == OP_DEQ);
                        end
`else
                        state <= ISSUE;
                        q_enq <= (pick_op == OP_ENQ);
                        q_deq <= (pick_op == OP_DEQ);
`endif
                    end
                end
                ISSUE: begin
                    // Head is sampled while the dequeue command is on the wire.
                    if (cur_op == OP_DEQ) begin
                        rsp_key <= q_dout;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (q_rdy) begin
                        state <= RESP;
                        ack   <= ONE << gnt_id;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    gnt_id <= '0;
                    ptr    <= (gnt_id == NW'(N - 1)) ? '0 : gnt_id + NW'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qq_arbiter.sv
// Directed bench for qq_arbiter with a small behavioural QuickQ (sorted, fixed busy time).
module tb_qq_arbiter;

    localparam int W        = 32;
    localparam int N        = 4;
    localparam int NW       = 2;
    localparam int CAP      = 8;
    localparam int BUSY_LEN = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_enq = '0;
    logic [N-1:0]    req_deq = '0;
    logic [N*W-1:0]  req_key = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [W-1:0]    rsp_key;
    logic            q_rdy;
    logic            q_full;
    logic            q_empty;
    logic [W-1:0]    q_dout;
    logic            q_enq;
    logic            q_deq;
    logic [W-1:0]    q_din;
    logic            busy;
    logic [NW-1:0]   gnt_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qq_arbiter #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_enq (req_enq),
        .req_deq (req_deq),
        .req_key (req_key),
        .ack     (ack),
        .err     (err),
        .rsp_key (rsp_key),
        .q_rdy   (q_rdy),
        .q_full  (q_full),
        .q_empty (q_empty),
        .q_dout  (q_dout),
        .q_enq   (q_enq),
        .q_deq   (q_deq),
        .q_din   (q_din),
        .busy    (busy),
        .gnt_id  (gnt_id)
    );

    // Behavioural QuickQ: ascending sorted storage, head is the minimum.
    logic [W-1:0] mem [CAP];
    int cnt;
    int bcnt;

    assign q_dout  = (cnt > 0) ? mem[0] : '0;
    assign q_empty = (cnt == 0);
    assign q_full  = (cnt == CAP);
    assign q_rdy   = (bcnt == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 0;
            bcnt <= 0;
        end else begin
            logic [W-1:0] nxt [CAP];
            int p;
            nxt = mem;
            if (q_enq && cnt < CAP) begin
                p = cnt;
                while (p > 0 && nxt[p-1] > q_din) begin
                    nxt[p] = nxt[p-1];
                    p--;
                end
                nxt[p] = q_din;
                mem <= nxt;
                cnt <= cnt + 1;
            end else if (q_deq && cnt > 0) begin
                for (int k = 0; k < CAP - 1; k++) nxt[k] = nxt[k+1];
                mem <= nxt;
                cnt <= cnt - 1;
            end
            if (q_enq || q_deq) bcnt <= BUSY_LEN;
            else if (bcnt > 0)  bcnt <= bcnt - 1;
        end
    end

    always @(negedge clk) begin
        checks++;
        assert (!(q_enq && q_deq)) else begin
            errors++;
            $error("FAIL cmd_excl observed=%0b%0b expected=not both", q_enq, q_deq);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            n++;
            if (q_enq || q_deq) break;
        end
        chk("cmd_seen", W'(q_enq | q_deq), W'(1));
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            n++;
            if (|ack) break;
        end
        chk("ack_seen", W'(|ack), W'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_enq = '0;
        req_deq = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic txn(input int i, input bit is_enq, input logic [W-1:0] key,
                       input logic [W-1:0] exp_rsp);
        int n1;
        int n2;
        req_key[i*W +: W] = key;
        if (is_enq) req_enq[i] = 1'b1;
        else        req_deq[i] = 1'b1;
        wait_cmd(n1);
        chk("cmd_enq", W'(q_enq), W'(is_enq));
        chk("cmd_deq", W'(q_deq), W'(!is_enq));
        if (is_enq) chk("q_din", q_din, key);
        chk("gnt_id", W'(gnt_id), W'(i));
        chk("busy", W'(busy), W'(1));
        wait_ack(n2);
        chk("latency", W'(n1 + n2), W'(3 + BUSY_LEN));
        chk("ack", W'(ack), W'(1 << i));
        chk("err", W'(err), W'(0));
        if (!is_enq) chk("rsp_key", rsp_key, exp_rsp);
        req_enq[i] = 1'b0;
        req_deq[i] = 1'b0;
        tick();
        chk("ack_drop", W'(ack), W'(0));
        chk("idle_busy", W'(busy), W'(0));
        chk("idle_gnt", W'(gnt_id), W'(0));
    endtask

    initial begin
        int n;
        int seen;
        int order [5];

        // Reset values
        tick();
        chk("rst_ack", W'(ack), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_q_enq", W'(q_enq), W'(0));
        chk("rst_q_deq", W'(q_deq), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_gnt", W'(gnt_id), W'(0));
        chk("rst_rsp", rsp_key, W'(0));
        chk("rst_q_din", q_din, W'(0));
        rst = 1'b0;
        tick();

        // Single enqueue from requester 2
        txn(2, 1'b1, 32'h15, 32'h0);

        // Fairness: four continuous enqueuers starting from ptr=0
        do_reset();
        order = '{0, 1, 2, 3, 0};
        req_key = {32'h44, 32'h33, 32'h22, 32'h11};
        req_enq = 4'hf;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            chk("rr_order", W'(ack), W'(1 << order[k]));
            tick();
            chk("rr_no_b2b", W'(ack), W'(0));
        end
        req_enq = '0;
        tick();

        // Dequeue returns the minimum first
        do_reset();
        txn(0, 1'b1, 32'h09, 32'h0);
        txn(0, 1'b1, 32'h03, 32'h0);
        txn(1, 1'b0, 32'h0, 32'h03);
        txn(1, 1'b0, 32'h0, 32'h09);
        tick();
        chk("rsp_hold", rsp_key, 32'h09);

        // Dequeue on an empty queue
`ifdef QQ_ARB_ERR_EN
        req_deq[0] = 1'b1;
        tick();
        chk("rej_ack", W'(ack), W'(4'b0001));
        chk("rej_err", W'(err), W'(4'b0001));
        chk("rej_no_deq", W'(q_deq), W'(0));
        req_deq[0] = 1'b0;
        tick();
        chk("rej_ack_drop", W'(ack), W'(0));
        chk("rej_err_drop", W'(err), W'(0));
`else
        req_deq[0] = 1'b1;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (|ack || q_deq || busy) seen++;
        end
        chk("empty_wait", W'(seen), W'(0));
        req_key[1*W +: W] = 32'h22;
        req_enq[1] = 1'b1;
        wait_ack(n);
        chk("unblock_enq_ack", W'(ack), W'(4'b0010));
        req_enq[1] = 1'b0;
        wait_ack(n);
        chk("unblock_deq_ack", W'(ack), W'(4'b0001));
        chk("unblock_rsp", rsp_key, 32'h22);
        chk("unblock_err", W'(err), W'(0));
        req_deq[0] = 1'b0;
        tick();
`endif

        // Simultaneous enqueue and dequeue from requester 3
        do_reset();
        req_key[3*W +: W] = 32'h40;
        req_enq[3] = 1'b1;
        req_deq[3] = 1'b1;
        wait_cmd(n);
        chk("sim_first_enq", W'(q_enq), W'(1));
        chk("sim_first_gnt", W'(gnt_id), W'(3));
        wait_ack(n);
        chk("sim_ack1", W'(ack), W'(4'b1000));
        req_enq[3] = 1'b0;
        wait_cmd(n);
        chk("sim_second_deq", W'(q_deq), W'(1));
        wait_ack(n);
        chk("sim_ack2", W'(ack), W'(4'b1000));
        chk("sim_rsp", rsp_key, 32'h40);
        req_deq[3] = 1'b0;
        tick();

        // Reset while waiting on QuickQ
        txn(1, 1'b1, 32'h55, 32'h0);
        req_key[2*W +: W] = 32'h11;
        req_enq[2] = 1'b1;
        wait_cmd(n);
        tick();
        chk("mid_busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("mid_ack", W'(ack), W'(0));
        chk("mid_err", W'(err), W'(0));
        chk("mid_q_enq", W'(q_enq), W'(0));
        chk("mid_q_deq", W'(q_deq), W'(0));
        chk("mid_busy0", W'(busy), W'(0));
        chk("mid_gnt", W'(gnt_id), W'(0));
        chk("mid_q_din", q_din, W'(0));
        req_enq = '0;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (|ack) seen++;
        end
        chk("mid_no_ack", W'(seen), W'(0));
        req_key[1*W +: W] = 32'h61;
        req_key[3*W +: W] = 32'h63;
        req_enq = 4'b1010;
        wait_cmd(n);
        chk("mid_ptr0_gnt", W'(gnt_id), W'(1));
        req_enq = '0;
        wait_ack(n);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
